// File: rtl/qos_wrr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : qos_wrr_arbiter
//  Purpose  : Weighted round-robin drain of four VC FIFOs into one egress
//             FIFO. Each word is tagged with its source VC. Pops stop while
//             the egress side is blocked.
//  Revision : 1.0  initial release
// ============================================================================
module qos_wrr_arbiter #(
  parameter int         DATA_W = 4,
  parameter logic [3:0] W0     = 4'd4,
  parameter logic [3:0] W1     = 4'd2,
  parameter logic [3:0] W2     = 4'd1,
  parameter logic [3:0] W3     = 4'd1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [3:0]        EMPTY_IN,
  input  logic [DATA_W-1:0] DATO_IN0,
  input  logic [DATA_W-1:0] DATO_IN1,
  input  logic [DATA_W-1:0] DATO_IN2,
  input  logic [DATA_W-1:0] DATO_IN3,
  input  logic              ALMOST_FULL_OUT,
  input  logic              FULL_OUT,
  output logic [3:0]        POP,
  output logic              PUSH,
  output logic [DATA_W-1:0] DATO_OUT,
  output logic [1:0]        VC_OUT,
  output logic [1:0]        STATE
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SERVE = 2'b01,
    HOLD  = 2'b10
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        ptr;
  logic [3:0]        credit;
  logic [1:0]        sel;
  logic [3:0]        credit_eff;
  logic [3:0]        credit_inc;
  logic [3:0]        weight_sel;
  logic              blocked;
  logic              any_ready;
  logic              pop_en;
  logic              s1_valid;
  logic [1:0]        s1_vc;
  logic [DATA_W-1:0] dato_mux;

  assign blocked   = ALMOST_FULL_OUT | FULL_OUT;
  assign any_ready = ~&EMPTY_IN;
  assign STATE     = state;

  // Pick the pointer VC if it has data, else the nearest non-empty VC after it.
  always_comb begin
    sel = ptr;
    for (int k = 3; k >= 1; k--) begin
      if (!EMPTY_IN[ptr + 2'(k)]) begin
        sel = ptr + 2'(k);
      end
    end
    if (!EMPTY_IN[ptr]) begin
      sel = ptr;
    end
  end

  // Weight of the selected VC; a VC reached by skipping starts a fresh turn.
  always_comb begin
    case (sel)
      2'd0:    weight_sel = W0;
      2'd1:    weight_sel = W1;
      2'd2:    weight_sel = W2;
      default: weight_sel = W3;
    endcase
    credit_eff = (sel == ptr) ? credit : 4'd0;
    credit_inc = credit_eff + 4'd1;
  end

  // Next-state and pop decode; blocked always wins over pop eligibility.
  always_comb begin
    state_nxt = state;
    pop_en    = 1'b0;
    case (state)
      IDLE: begin
        if (any_ready) begin
          state_nxt = blocked ? HOLD : SERVE;
        end
      end
      SERVE: begin
        pop_en = any_ready & ~blocked;
        if (blocked) begin
          state_nxt = HOLD;
        end else if (!any_ready) begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (!blocked) begin
          state_nxt = any_ready ? SERVE : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    POP = pop_en ? (4'b0001 << sel) : 4'b0000;
  end

  // State register.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Turn bookkeeping: advance the pointer once the selected VC uses its weight.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      ptr    <= 2'd0;
      credit <= 4'd0;
    end else if (pop_en) begin
      if (credit_inc == weight_sel) begin
        ptr    <= sel + 2'd1;
        credit <= 4'd0;
      end else begin
        ptr    <= sel;
        credit <= credit_inc;
      end
    end
  end

  // Source FIFO data arrives one cycle after its pop; pick it by the tag.
  always_comb begin
    case (s1_vc)
      2'd0:    dato_mux = DATO_IN0;
      2'd1:    dato_mux = DATO_IN1;
      2'd2:    dato_mux = DATO_IN2;
      default: dato_mux = DATO_IN3;
    endcase
  end

  // Two-stage push pipeline: tag the pop, then capture the word and push it.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      s1_valid <= 1'b0;
      s1_vc    <= 2'd0;
      PUSH     <= 1'b0;
      DATO_OUT <= '0;
      VC_OUT   <= 2'd0;
    end else begin
      s1_valid <= pop_en;
      s1_vc    <= sel;
      PUSH     <= s1_valid;
      if (s1_valid) begin
        DATO_OUT <= dato_mux;
        VC_OUT   <= s1_vc;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qos_wrr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_qos_wrr_arbiter
//  Purpose  : Directed self-checking bench for qos_wrr_arbiter with
//             behavioural VC FIFOs and an optional draining egress FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module tb_qos_wrr_arbiter;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    empty_in;
  logic [DW-1:0] dato [4];
  logic          almost_full;
  logic          full_out;
  logic [3:0]    pop;
  logic          push;
  logic [DW-1:0] dato_out;
  logic [1:0]    vc_out;
  logic [1:0]    state;

  qos_wrr_arbiter #(.DATA_W(DW)) dut (
    .CLOCK(clk), .RESET(rst_n), .EMPTY_IN(empty_in),
    .DATO_IN0(dato[0]), .DATO_IN1(dato[1]), .DATO_IN2(dato[2]), .DATO_IN3(dato[3]),
    .ALMOST_FULL_OUT(almost_full), .FULL_OUT(full_out),
    .POP(pop), .PUSH(push), .DATO_OUT(dato_out), .VC_OUT(vc_out), .STATE(state)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural VC FIFOs ----------------
  logic [DW-1:0] mem [4][16];
  int            cnt [4] = '{default: 0};
  int            rd_ptr [4] = '{default: 0};
  logic          clr = 1'b0;
  int            pop_empty = 0;

  always_comb begin
    empty_in = 4'b1111;
    for (int i = 0; i < 4; i++) empty_in[i] = (rd_ptr[i] >= cnt[i]);
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4; i++) rd_ptr[i] <= 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pop[i]) begin
          if (rd_ptr[i] >= cnt[i]) pop_empty <= pop_empty + 1;
          dato[i]   <= mem[i][rd_ptr[i] & 15];
          rd_ptr[i] <= rd_ptr[i] + 1;
        end
      end
    end
  end

  // ---------------- egress model and push log ----------------
  logic          eg_en = 1'b0;
  logic          af_force = 1'b0;
  int            eg_cnt = 0;
  int            tick = 0;
  int            log_n = 0;
  int            ovf = 0;
  int            full_push = 0;
  logic          saw_hold = 1'b0;
  logic [1:0]    log_vc [64];
  logic [DW-1:0] log_d [64];
  logic          drain;

  assign drain       = eg_en && (tick == 0) && (eg_cnt > 0);
  assign almost_full = eg_en ? (eg_cnt >= 6) : af_force;
  assign full_out    = eg_en && (eg_cnt >= 8);

  always @(posedge clk) begin
    if (clr) begin
      log_n  <= 0;
      eg_cnt <= 0;
      tick   <= 0;
    end else begin
      tick <= (tick == 2) ? 0 : tick + 1;
      if (push) begin
        if (log_n < 64) begin
          log_vc[log_n] <= vc_out;
          log_d[log_n]  <= dato_out;
        end
        log_n <= log_n + 1;
        if (full_out) full_push <= full_push + 1;
      end
      if (eg_en) begin
        eg_cnt <= eg_cnt + (push ? 1 : 0) - (drain ? 1 : 0);
        if (push && !drain && eg_cnt >= 8) ovf <= ovf + 1;
        if (state == 2'b10) saw_hold <= 1'b1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] tag8(input int v, input int i);
    logic [1:0] vv;
    logic [5:0] ii;
    vv = v[1:0];
    ii = i[5:0];
    return {vv, ii};
  endfunction

  task automatic load(input int v, input int n);
    for (int i = 0; i < n; i++) mem[v][i] = tag8(v, i);
    cnt[v] = n;
  endtask

  task automatic begin_test();
    rst_n    = 1'b0;
    af_force = 1'b0;
    for (int v = 0; v < 4; v++) cnt[v] = 0;
    clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_pushes(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (log_n < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_done"}, (log_n >= n), 1);
  endtask

  task automatic check_seq(input string tag);
    int idx [4];
    for (int v = 0; v < 4; v++) idx[v] = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk({tag, "_vc"}, log_vc[i], exp_q[i]);
      chk({tag, "_data"}, log_d[i], tag8(exp_q[i], idx[exp_q[i]]));
      idx[exp_q[i]]++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int counts [4];
    int c;

    // Reset state
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rst_pop", pop, 0);
    chk("rst_push", push, 0);
    chk("rst_data", dato_out, 0);
    chk("rst_vc", vc_out, 0);
    chk("rst_state", state, 0);

    // Single VC: VC2 holds five words
    begin_test();
    load(2, 5);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk); #1;
      chk("sv_pop", pop, (k <= 5) ? 4'b0100 : 4'b0000);
      chk("sv_push", push, (k >= 3) ? 1 : 0);
      if (k >= 3) begin
        chk("sv_data", dato_out, tag8(2, k - 3));
        chk("sv_vc", vc_out, 2);
      end
    end
    chk("sv_idle", state, 0);

    // All VCs backlogged
    begin_test();
    for (int v = 0; v < 4; v++) load(v, 10);
    wait_pushes("bl", 16, 100);
    exp_q.delete();
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
      exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    end
    check_seq("bl");
    for (int v = 0; v < 4; v++) counts[v] = 0;
    for (int i = 0; i < 16; i++) counts[log_vc[i]]++;
    chk("bl_cnt0", counts[0], 8);
    chk("bl_cnt1", counts[1], 4);
    chk("bl_cnt2", counts[2], 2);
    chk("bl_cnt3", counts[3], 2);

    // Reset mid-stream: trigger on the second VC1 word of a turn, when ptr=3
    #1;
    c = 0;
    while (!(push && vc_out == 2'd1 && dato_out[0]) && c < 100) begin
      @(negedge clk); #1;
      c++;
    end
    chk("rs_trigger", (push && vc_out == 2'd1), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_pop", pop, 0);
    chk("rs_push", push, 0);
    chk("rs_data", dato_out, 0);
    chk("rs_vc", vc_out, 0);
    chk("rs_state", state, 0);
    for (int v = 0; v < 4; v++) cnt[v] = 0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    load(0, 2);
    load(3, 2);
    #1 chk("rs_hold_push", push, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1 chk("rs_rel_push", push, 0);
      @(negedge clk);
    end
    wait_pushes("rs", 4, 50);
    exp_q.delete();
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(3);
    check_seq("rs");

    // Empty-skip
    begin_test();
    load(0, 2);
    load(1, 3);
    wait_pushes("es", 5, 50);
    exp_q.delete();
    exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
    check_seq("es");
    repeat (3) @(negedge clk);
    #1 chk("es_idle", state, 0);

    // Back-pressure during a VC0 burst
    begin_test();
    load(0, 10);
    load(1, 4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      af_force = (k >= 3 && k <= 5);
      #1;
      chk("bp_pop", pop, (k <= 2 || k >= 7) ? 4'b0001 : 4'b0000);
      chk("bp_push", push, (k == 3 || k == 4) ? 1 : 0);
      if (k == 4 || k == 5) chk("bp_hold", state, 2);
      if (k == 7) chk("bp_serve", state, 1);
    end
    wait_pushes("bp", 8, 50);
    exp_q.delete();
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
    check_seq("bp");

    // Four-VC dump into a slowly draining 8-deep egress FIFO
    begin_test();
    eg_en = 1'b1;
    for (int v = 0; v < 4; v++) load(v, 8);
    wait_pushes("dump", 32, 600);
    exp_q.delete();
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
      exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    end
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    end
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back(2); exp_q.push_back(3);
    end
    check_seq("dump");
    chk("dump_ovf", ovf, 0);
    chk("dump_hold_seen", saw_hold, 1);
    repeat (4) @(negedge clk);
    chk("dump_total", log_n, 32);

    chk("full_push", full_push, 0);
    chk("pop_empty", pop_empty, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qos_wrr_arbiter.md
Name: qos_wrr_arbiter

Overview:
- Downstream consumer of the per-virtual-channel FIFO instances.
- Pops words from four VC FIFOs using weighted round-robin and pushes them, tagged with their source VC, into a single egress FIFO.
- Stops issuing pops on egress back-pressure, so the egress FIFO is never pushed while full.

Parameters:
- DATA_W, 4, word width; matches FIFO data width.
- W0, 4, VC0 weight: consecutive pops allowed per turn (1..15).
- W1, 2, VC1 weight.
- W2, 1, VC2 weight.
- W3, 1, VC3 weight.

Ports:
- CLOCK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- EMPTY_IN  in  4  EMPTY flags of VC FIFOs 0..3.
- DATO_IN0..DATO_IN3  in  DATA_W each  DATO_OUT of VC FIFOs 0..3.
- ALMOST_FULL_OUT  in  1  ALMOST_FULL of the egress FIFO.
- FULL_OUT  in  1  FULL of the egress FIFO.
- POP  out  4  one-hot pop strobes to VC FIFOs 0..3.
- PUSH  out  1  push strobe to the egress FIFO.
- DATO_OUT  out  DATA_W  word to the egress FIFO.
- VC_OUT  out  2  source VC of DATO_OUT.
- STATE  out  2  FSM state, for debug.

Behaviour:
- Reset (RESET=0, async) clears all of the following:
  - POP=0, PUSH=0, DATO_OUT=0, VC_OUT=0.
  - Pointer ptr=0, credit=0, STATE=IDLE.
  - Pipeline valid bits.
- Reset mid-operation drops in-flight words; no PUSH is issued for them.
- FIFO read timing: a VC FIFO presents popped data on its DATO_OUT in the cycle after POP.
- Latency, with POP[i]=1 in cycle N:
  - Arbiter samples DATO_INi and i at the end of cycle N+1.
  - PUSH=1, DATO_OUT and VC_OUT valid during cycle N+2.
- Pipeline is fully pipelined: one pop per cycle, sustained.
- Blocked = ALMOST_FULL_OUT | FULL_OUT. The egress ALMOST_FULL threshold must leave at least 2 free entries to cover in-flight words.
- Selection (combinational):
  - sel = ptr if EMPTY_IN[ptr]=0.
  - Otherwise sel = first non-empty VC searching ptr+1, ptr+2, ptr+3 (mod 4).
  - credit_eff = credit if sel==ptr, else 0.
- FSM states:
  - IDLE (00): all EMPTY_IN=1. POP=0. Go to SERVE when any EMPTY_IN=0 and not blocked; go to HOLD when any EMPTY_IN=0 and blocked.
  - SERVE (01): POP[sel]=1 this cycle when some VC is non-empty and not blocked; POP=0 otherwise. Go to HOLD if blocked; go to IDLE if all empty; otherwise stay.
  - HOLD (10): POP=0; ptr and credit are frozen. Go to SERVE when unblocked and any VC is non-empty; go to IDLE when unblocked and all are empty.
  - Encoding 11 is unreachable and recovers to IDLE.
- POP is a combinational decode of STATE plus current inputs, so a pop never occurs in a cycle where blocked=1 or EMPTY_IN[sel]=1.
- Credit update on each pop:
  - If credit_eff+1 == W[sel]: ptr<=(sel+1) mod 4, credit<=0.
  - Otherwise: ptr<=sel, credit<=credit_eff+1.
  - No pop: ptr and credit hold.
- Credit register is 4 bits; the weight comparison is equality, so credit never exceeds 15.
- Empty-skip: a VC that goes empty mid-turn forfeits its remaining credit; service moves to the next non-empty VC with a fresh credit.
- Single active VC: it is popped every cycle; its credit wraps per weight and ptr re-selects it.
- Simultaneous blocked assertion and pop eligibility: blocked wins, so no pop.
- Words already in the pipeline still push while blocked.

Test Plan:
- Reset mid-stream:
  - Stimulus: assert RESET=0 asynchronously while PUSH=1.
  - Required: all outputs go to 0 immediately; no PUSH afterwards until new pops; ptr=0 on release.
- Single VC:
  - Stimulus: VC2 holds 5 words A..E, other VCs empty, no back-pressure.
  - Required: POP=0100 for 5 consecutive cycles; PUSH on cycles +2..+6 with DATO_OUT=A..E and VC_OUT=2; then STATE=IDLE.
- All VCs backlogged (10 words each), weights 4,2,1,1:
  - Required VC_OUT sequence: 0,0,0,0,1,1,2,3, repeating.
  - Over 16 pushes: VC0=8, VC1=4, VC2=2, VC3=2.
- Empty-skip:
  - Stimulus: VC0 holds 2 words, VC1 holds 3, VC2/VC3 empty.
  - Required VC_OUT sequence: 0,0,1,1,1.
  - VC0 forfeits its remaining 2 credits; after VC1 reaches its weight of 2, ptr=2, and the search wraps back to VC1 for the third word.
- Back-pressure:
  - Stimulus: raise ALMOST_FULL_OUT for 3 cycles during a VC0 burst.
  - Required: POP=0 during those cycles, STATE=HOLD; the 2 in-flight words still push.
  - On release, service resumes on VC0 with the preserved credit.
  - Across the run, no push is ever issued while FULL_OUT=1.
- Four-VC dump:
  - Stimulus: 8-deep VC FIFOs all full, 8-deep egress FIFO draining.
  - Required: the egress FIFO never overflows; all 32 words are delivered in WRR order with no loss.
